uart_hash_frame_ctrl: RTL and testbench
=======================================

// Module: uart_hash_frame_ctrl
// PURPOSE
//  Parametrised framing controller between the UART byte stream (uart_rx/uart_tx cores) and a hash core.
//  Successor to the 0x01/0xFF-terminated controller: uses a length-prefixed binary-safe frame (payload may hold any byte).
//  Replies with the digest as lowercase hex or raw binary, and reports errors (zero length, RX timeout) as single bytes.
//  Contains no UART or hash instances; the top level wires both to this block.
// PARAMETERS
//  DIGEST_W     256        digest width in bits; multiple of 8
//  LEN_BYTES    2          length-field bytes, big-endian, 1..4
//  TIMEOUT_CYC  2_700_000  max idle cycles between RX bytes inside a frame; 0 = timeout disabled
//  APPEND_CRLF  0          1 = append 0x0D 0x0A after a hex reply (not after raw or error replies)
//  CMD_HEX      8'h01      command byte: reply in hex
//  CMD_RAW      8'h02      command byte: reply in raw binary
// PORTS
//  clk           in   1         single clock
//  rst           in   1         synchronous, active-high reset
//  rx_data       in   8         byte from uart_rx
//  rx_valid      in   1         1-cycle strobe; byte is always consumed (no RX backpressure)
//  tx_data       out  8         byte to uart_tx
//  tx_data_valid out  1         byte offered; held until accepted
//  tx_data_ready in   1         uart_tx idle; transfer when valid && ready
//  hash_start    out  1         1-cycle pulse; reinitialises the hash core
//  hash_data     out  8         payload byte to the hash core
//  hash_valid    out  1         1-cycle strobe per payload byte
//  hash_last     out  1         high with hash_valid on the final payload byte only
//  hash_out      in   DIGEST_W  digest from the hash core, MSB first
//  hash_done     in   1         digest valid strobe
//  busy          out  1         state != IDLE
//  err_cmd       out  1         1-cycle pulse: unknown command byte in IDLE
//  rx_drop       out  1         1-cycle pulse: rx_valid seen in WAIT_DONE, SEND or ERR (byte discarded)
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE; counters and the digest register cleared. Reset wins over every event.
//   Reset in any state aborts the frame, with no reply. tx_data_valid is 0 the cycle after rst is sampled.
//  Frame: CMD, LEN[LEN_BYTES] (big-endian), LEN payload bytes. No terminator.
//  IDLE: rx_valid with CMD_HEX or CMD_RAW latches the mode and goes to LEN. Any other byte pulses err_cmd and stays.
//  LEN: shifts in LEN_BYTES bytes. After the final byte:
//   LEN == 0 -> ERR with code 0x45 ('E'); no hash_start.
//   LEN != 0 -> hash_start pulses the next cycle; go to PAYLOAD with remaining = LEN.
//  PAYLOAD: each rx_valid drives hash_data/hash_valid the next cycle (1-cycle registered latency).
//   hash_last is asserted with the byte where remaining hits 0; go to WAIT_DONE.
//   Byte values are not interpreted (0x01, 0xFF etc. are plain data).
//  Timeout: in LEN or PAYLOAD, a counter clears on each rx_valid.
//   When it reaches TIMEOUT_CYC -> ERR with code 0x54 ('T'). The next hash_start reinitialises the core.
//  WAIT_DONE: on hash_done, capture hash_out into the digest register and go to SEND. There is no timeout here.
//  SEND: nibble or byte index starts at 0, MSB first.
//   hex: DIGEST_W/4 chars; 0-9 -> 0x30+n, a-f -> 0x61+n-10; then CR LF if APPEND_CRLF.
//   raw: DIGEST_W/8 bytes.
//   After the last accepted byte, go to IDLE.
//  ERR: offer one error byte, then go to IDLE.
//  TX handshake: tx_data is loaded when tx_data_valid rises and stays stable while valid && !ready.
//   Index advances only on valid && ready. No byte is skipped or duplicated under any ready pattern.
//   A new byte may be offered the cycle after acceptance.
//  hash_done outside WAIT_DONE is ignored. hash_out changes after capture do not affect the reply.
//  Simultaneous rx_valid and timeout expiry in the same cycle: the byte wins and the counter clears.
// TESTING
//  01 00 03 61 62 63, core model returns SHA-256("abc")
//   -> 3 hash_valid; hash_last on 0x63; tx "ba7816bf...f20015ad" (64 chars).
//  02 00 03 61 62 63 -> 32 tx bytes ba 78 16 bf ... 15 ad. With APPEND_CRLF=1 in hex mode -> 66 bytes ending 0D 0A.
//  01 00 02 FF 01 -> hash_data FF then 01 (last on 01); 0xFF is not treated as terminator.
//  01 00 00 -> single tx 0x45, no hash_start. Then 7A in IDLE -> err_cmd pulse, no tx.
//  TIMEOUT_CYC=100: 01 00 05 61, then silence -> tx 0x54 within 102 cycles, busy=0.
//   A following valid frame hashes correctly.
//  tx_data_ready randomly low 70% of cycles -> exact 64-char sequence, tx_data stable while unaccepted.
//   rst mid-SEND -> no further bytes; IDLE.

Source files
------------

// File: rtl/uart_hash_frame_ctrl.sv
// uart_hash_frame_ctrl
// Framing controller between a UART byte stream and a hash core. Accepts a
// length-prefixed binary-safe frame (CMD, LEN big-endian, LEN payload bytes),
// streams the payload into the hash core, and replies with the digest as
// lowercase hex (optionally followed by CR LF) or raw bytes. Errors (zero
// length, RX timeout) are reported as a single byte ('E' / 'T').
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   rx_data, rx_valid             byte stream from uart_rx (always consumed)
//   tx_data, tx_data_valid,
//   tx_data_ready                 byte stream to uart_tx (valid/ready)
//   hash_start                    pulse that reinitialises the hash core
//   hash_data, hash_valid,
//   hash_last                     payload bytes to the hash core
//   hash_out, hash_done           digest (MSB first) and its valid strobe
//   busy                          controller is not idle
//   err_cmd                       pulse: unknown command byte
//   rx_drop                       pulse: byte received while replying/waiting
module uart_hash_frame_ctrl #(
    parameter int unsigned DIGEST_W    = 256,
    parameter int unsigned LEN_BYTES   = 2,
    parameter int unsigned TIMEOUT_CYC = 2_700_000,
    parameter int unsigned APPEND_CRLF = 0,
    parameter logic [7:0]  CMD_HEX     = 8'h01,
    parameter logic [7:0]  CMD_RAW     = 8'h02
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [7:0]          rx_data,
    input  logic                rx_valid,
    output logic [7:0]          tx_data,
    output logic                tx_data_valid,
    input  logic                tx_data_ready,
    output logic                hash_start,
    output logic [7:0]          hash_data,
    output logic                hash_valid,
    output logic                hash_last,
    input  logic [DIGEST_W-1:0] hash_out,
    input  logic                hash_done,
    output logic                busy,
    output logic                err_cmd,
    output logic                rx_drop
);

    localparam int unsigned LW       = LEN_BYTES * 8;
    localparam int unsigned NHEX     = DIGEST_W / 4;
    localparam int unsigned NRAW     = DIGEST_W / 8;
    localparam int unsigned IW       = $clog2(NHEX + 3);
    localparam int unsigned LCW      = (LEN_BYTES > 1) ? $clog2(LEN_BYTES) : 1;
    localparam int unsigned TW       = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam int unsigned HEX_LAST = NHEX - 1 + ((APPEND_CRLF != 0) ? 2 : 0);
    localparam int unsigned RAW_LAST = NRAW - 1;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_LEN     = 3'd1;
    localparam logic [2:0] S_PAYLOAD = 3'd2;
    localparam logic [2:0] S_WAIT    = 3'd3;
    localparam logic [2:0] S_SEND    = 3'd4;
    localparam logic [2:0] S_ERR     = 3'd5;

    localparam logic [7:0] ERR_ZERO = 8'h45;
    localparam logic [7:0] ERR_TMO  = 8'h54;

    logic [2:0]          state_q, state_d;
    logic                mode_hex_q, mode_hex_d;
    logic [LW-1:0]       len_q, len_d;
    logic [LCW-1:0]      len_cnt_q, len_cnt_d;
    logic [LW-1:0]       rem_q, rem_d;
    logic [TW-1:0]       tmo_q, tmo_d;
    logic [DIGEST_W-1:0] digest_q, digest_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic [7:0]          tx_data_q, tx_data_d;
    logic                tx_valid_q, tx_valid_d;
    logic                hash_start_q, hash_start_d;
    logic [7:0]          hash_data_q, hash_data_d;
    logic                hash_valid_q, hash_valid_d;
    logic                hash_last_q, hash_last_d;
    logic                busy_q, busy_d;
    logic                err_cmd_q, err_cmd_d;
    logic                rx_drop_q, rx_drop_d;

    // Combinational helpers
    logic [LW-1:0]       len_full;
    logic [TW-1:0]       tmo_inc;
    logic                tmo_hit;
    logic [DIGEST_W-1:0] dig_hex, dig_raw;
    logic [3:0]          nib;
    logic [7:0]          hex_char;
    logic [7:0]          reply_byte;
    logic [IW-1:0]       last_idx;

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            mode_hex_q   <= 1'b0;
            len_q        <= '0;
            len_cnt_q    <= '0;
            rem_q        <= '0;
            tmo_q        <= '0;
            digest_q     <= '0;
            idx_q        <= '0;
            tx_data_q    <= '0;
            tx_valid_q   <= 1'b0;
            hash_start_q <= 1'b0;
            hash_data_q  <= '0;
            hash_valid_q <= 1'b0;
            hash_last_q  <= 1'b0;
            busy_q       <= 1'b0;
            err_cmd_q    <= 1'b0;
            rx_drop_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            mode_hex_q   <= mode_hex_d;
            len_q        <= len_d;
            len_cnt_q    <= len_cnt_d;
            rem_q        <= rem_d;
            tmo_q        <= tmo_d;
            digest_q     <= digest_d;
            idx_q        <= idx_d;
            tx_data_q    <= tx_data_d;
            tx_valid_q   <= tx_valid_d;
            hash_start_q <= hash_start_d;
            hash_data_q  <= hash_data_d;
            hash_valid_q <= hash_valid_d;
            hash_last_q  <= hash_last_d;
            busy_q       <= busy_d;
            err_cmd_q    <= err_cmd_d;
            rx_drop_q    <= rx_drop_d;
        end
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d      = state_q;
        mode_hex_d   = mode_hex_q;
        len_d        = len_q;
        len_cnt_d    = len_cnt_q;
        rem_d        = rem_q;
        tmo_d        = tmo_q;
        digest_d     = digest_q;
        idx_d        = idx_q;
        tx_data_d    = tx_data_q;
        tx_valid_d   = tx_valid_q;
        hash_start_d = 1'b0;
        hash_data_d  = hash_data_q;
        hash_valid_d = 1'b0;
        hash_last_d  = 1'b0;
        err_cmd_d    = 1'b0;
        rx_drop_d    = 1'b0;

        len_full = (len_q << 8) | LW'(rx_data);
        tmo_inc  = tmo_q + TW'(1);
        tmo_hit  = (TIMEOUT_CYC != 0) && (tmo_inc == TW'(TIMEOUT_CYC));

        // Reply byte at idx_q: shift the wanted nibble/byte to the top
        dig_hex  = digest_q << {idx_q, 2'b00};
        dig_raw  = digest_q << {idx_q, 3'b000};
        nib      = dig_hex[DIGEST_W-1 -: 4];
        hex_char = (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h57 + {4'h0, nib});
        if (mode_hex_q) begin
            if (idx_q < IW'(NHEX))       reply_byte = hex_char;
            else if (idx_q == IW'(NHEX)) reply_byte = 8'h0D;
            else                         reply_byte = 8'h0A;
        end else begin
            reply_byte = dig_raw[DIGEST_W-1 -: 8];
        end
        last_idx = mode_hex_q ? IW'(HEX_LAST) : IW'(RAW_LAST);

        case (state_q)
            S_IDLE: begin
                if (rx_valid) begin
                    if (rx_data == CMD_HEX || rx_data == CMD_RAW) begin
                        mode_hex_d = (rx_data == CMD_HEX);
                        len_d      = '0;
                        len_cnt_d  = '0;
                        tmo_d      = '0;
                        state_d    = S_LEN;
                    end else begin
                        err_cmd_d = 1'b1;
                    end
                end
            end
            S_LEN: begin
                // A byte arriving on the expiry cycle wins over the timeout
                if (rx_valid) begin
                    tmo_d = '0;
                    len_d = len_full;
                    if (len_cnt_q == LCW'(LEN_BYTES - 1)) begin
                        if (len_full == '0) begin
                            tx_data_d  = ERR_ZERO;
                            tx_valid_d = 1'b1;
                            state_d    = S_ERR;
                        end else begin
                            hash_start_d = 1'b1;
                            rem_d        = len_full;
                            state_d      = S_PAYLOAD;
                        end
                    end else begin
                        len_cnt_d = len_cnt_q + LCW'(1);
                    end
                end else if (tmo_hit) begin
                    tx_data_d  = ERR_TMO;
                    tx_valid_d = 1'b1;
                    state_d    = S_ERR;
                end else begin
                    tmo_d = tmo_inc;
                end
            end
            S_PAYLOAD: begin
                if (rx_valid) begin
                    tmo_d        = '0;
                    hash_data_d  = rx_data;
                    hash_valid_d = 1'b1;
                    rem_d        = rem_q - LW'(1);
                    if (rem_q == LW'(1)) begin
                        hash_last_d = 1'b1;
                        state_d     = S_WAIT;
                    end
                end else if (tmo_hit) begin
                    tx_data_d  = ERR_TMO;
                    tx_valid_d = 1'b1;
                    state_d    = S_ERR;
                end else begin
                    tmo_d = tmo_inc;
                end
            end
            S_WAIT: begin
                rx_drop_d = rx_valid;
                if (hash_done) begin
                    digest_d = hash_out;
                    idx_d    = '0;
                    state_d  = S_SEND;
                end
            end
            S_SEND: begin
                // Load a byte while idle; tx_data then holds until accepted
                rx_drop_d = rx_valid;
                if (!tx_valid_q) begin
                    tx_data_d  = reply_byte;
                    tx_valid_d = 1'b1;
                end else if (tx_data_ready) begin
                    tx_valid_d = 1'b0;
                    if (idx_q == last_idx) state_d = S_IDLE;
                    else                   idx_d   = idx_q + IW'(1);
                end
            end
            S_ERR: begin
                rx_drop_d = rx_valid;
                if (tx_valid_q && tx_data_ready) begin
                    tx_valid_d = 1'b0;
                    state_d    = S_IDLE;
                end
            end
            default: begin
                tx_valid_d = 1'b0;
                state_d    = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    assign tx_data       = tx_data_q;
    assign tx_data_valid = tx_valid_q;
    assign hash_start    = hash_start_q;
    assign hash_data     = hash_data_q;
    assign hash_valid    = hash_valid_q;
    assign hash_last     = hash_last_q;
    assign busy          = busy_q;
    assign err_cmd       = err_cmd_q;
    assign rx_drop       = rx_drop_q;

endmodule

// File: tb/tb_uart_hash_frame_ctrl.sv
// Directed bench for uart_hash_frame_ctrl: hex/raw replies of SHA-256("abc"),
// binary-safe payload, zero length, unknown command, RX timeout, random TX
// backpressure and reset mid-reply. A second instance adds CR LF to hex replies.
module tb_uart_hash_frame_ctrl;

    localparam logic [255:0] DIG =
        256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;

    logic         clk;
    logic         rst;
    logic [7:0]   rx_data;
    logic         rx_valid;
    logic         tx_ready;
    logic [255:0] hash_out;
    logic         hash_done;

    logic [7:0] tx_data,    tx_data2;
    logic       tx_valid,   tx_valid2;
    logic       hash_start, hash_start2;
    logic [7:0] hash_data,  hash_data2;
    logic       hash_valid, hash_valid2;
    logic       hash_last,  hash_last2;
    logic       busy,       busy2;
    logic       err_cmd,    err_cmd2;
    logic       rx_drop,    rx_drop2;

    int checks   = 0;
    int failures = 0;
    bit rdy_rand = 0;

    // Monitor state
    logic [7:0] tx_q[$];
    logic [7:0] tx2_q[$];
    logic [7:0] hv_q[$];
    logic [7:0] last_q[$];
    int n_start  = 0;
    int n_errcmd = 0;
    int n_drop   = 0;
    int stab_err = 0;
    int done_cnt = 0;
    bit pend = 0, pend2 = 0;
    logic [7:0] pend_d = 0, pend_d2 = 0;

    string exp_hex = "ba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad";

    uart_hash_frame_ctrl #(
        .DIGEST_W(256), .LEN_BYTES(2), .TIMEOUT_CYC(100), .APPEND_CRLF(0),
        .CMD_HEX(8'h01), .CMD_RAW(8'h02)
    ) dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
        .tx_data(tx_data), .tx_data_valid(tx_valid), .tx_data_ready(tx_ready),
        .hash_start(hash_start), .hash_data(hash_data), .hash_valid(hash_valid),
        .hash_last(hash_last), .hash_out(hash_out), .hash_done(hash_done),
        .busy(busy), .err_cmd(err_cmd), .rx_drop(rx_drop)
    );

    uart_hash_frame_ctrl #(
        .DIGEST_W(256), .LEN_BYTES(2), .TIMEOUT_CYC(100), .APPEND_CRLF(1),
        .CMD_HEX(8'h01), .CMD_RAW(8'h02)
    ) dut_crlf (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
        .tx_data(tx_data2), .tx_data_valid(tx_valid2), .tx_data_ready(tx_ready),
        .hash_start(hash_start2), .hash_data(hash_data2), .hash_valid(hash_valid2),
        .hash_last(hash_last2), .hash_out(hash_out), .hash_done(hash_done),
        .busy(busy2), .err_cmd(err_cmd2), .rx_drop(rx_drop2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change at posedge+1, so negedge sees what the next posedge consumes
    always @(negedge clk) begin
        if (tx_valid && tx_ready)   tx_q.push_back(tx_data);
        if (tx_valid2 && tx_ready)  tx2_q.push_back(tx_data2);
        if (pend && tx_data !== pend_d)    stab_err++;
        if (pend2 && tx_data2 !== pend_d2) stab_err++;
        pend    = !rst && tx_valid && !tx_ready;
        pend_d  = tx_data;
        pend2   = !rst && tx_valid2 && !tx_ready;
        pend_d2 = tx_data2;
        if (hash_valid) hv_q.push_back(hash_data);
        if (hash_valid && hash_last) last_q.push_back(hash_data);
        if (hash_start) n_start++;
        if (err_cmd)    n_errcmd++;
        if (rx_drop)    n_drop++;
        if (hash_valid && hash_last) done_cnt = 4;
        else if (done_cnt > 0)       done_cnt--;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock step; also drives TX ready and the hash core model
    task automatic tick();
        @(posedge clk);
        #1;
        rx_valid  = 1'b0;
        tx_ready  = rdy_rand ? ($urandom_range(0, 9) >= 7) : 1'b1;
        hash_done = (done_cnt == 1);
        hash_out  = (done_cnt == 1) ? DIG : ~DIG;
    endtask

    task automatic send_byte(input logic [7:0] b);
        tick();
        rx_valid = 1'b1;
        rx_data  = b;
    endtask

    task automatic send_abc(input logic [7:0] cmd);
        send_byte(cmd);
        send_byte(8'h00);
        send_byte(8'h03);
        send_byte(8'h61);
        send_byte(8'h62);
        send_byte(8'h63);
    endtask

    task automatic wait_idle(input int budget, input string tag);
        int n = 0;
        do begin
            tick();
            n++;
        end while ((busy || busy2) && n < budget);
        chk({tag, "_idle"}, 64'({busy, busy2}), 64'd0);
    endtask

    task automatic chk_hex(input int b0, input string tag);
        int bad = 0;
        chk({tag, "_len"}, 64'(tx_q.size() - b0), 64'd64);
        for (int i = 0; i < 64; i++)
            if (b0 + i < tx_q.size() && tx_q[b0 + i] !== exp_hex[i]) bad++;
        chk({tag, "_chars_bad"}, 64'(bad), 64'd0);
    endtask

    initial begin
        int b0, b2, h0, l0, s0, e0, d0, n;
        int bad;
        logic [255:0] t;

        rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00;
        tx_ready = 1'b1; hash_done = 1'b0; hash_out = '0;

        // Reset state
        repeat (3) tick();
        chk("rst_tx_valid",   64'(tx_valid),   64'd0);
        chk("rst_tx_data",    64'(tx_data),    64'd0);
        chk("rst_busy",       64'(busy),       64'd0);
        chk("rst_hash_start", 64'(hash_start), 64'd0);
        chk("rst_hash_valid", 64'(hash_valid), 64'd0);
        chk("rst_err_cmd",    64'({err_cmd, rx_drop}), 64'd0);
        rst = 1'b0;
        tick();

        // Hex reply of "abc", plus CR LF on the second instance
        b0 = tx_q.size(); b2 = tx2_q.size(); h0 = hv_q.size(); l0 = last_q.size(); s0 = n_start;
        send_abc(8'h01);
        wait_idle(2000, "hex");
        chk("hex_hash_start", 64'(n_start - s0), 64'd1);
        chk("hex_hv_count",   64'(hv_q.size() - h0), 64'd3);
        chk("hex_hv_bytes",   64'({hv_q[h0], hv_q[h0+1], hv_q[h0+2]}), 64'h616263);
        chk("hex_last_count", 64'(last_q.size() - l0), 64'd1);
        chk("hex_last_byte",  64'(last_q[l0]), 64'h63);
        chk_hex(b0, "hex");
        chk("crlf_len",  64'(tx2_q.size() - b2), 64'd66);
        chk("crlf_tail", 64'({tx2_q[b2+64], tx2_q[b2+65]}), 64'h0D0A);
        chk("crlf_head", 64'({tx2_q[b2], tx2_q[b2+63]}), 64'h6264);

        // Raw reply, with a stray byte during the reply
        b0 = tx_q.size(); b2 = tx2_q.size(); d0 = n_drop;
        send_abc(8'h02);
        n = 0;
        while (!tx_valid && n < 200) begin tick(); n++; end
        chk("raw_reply_start", 64'(tx_valid), 64'd1);
        send_byte(8'h33);
        wait_idle(2000, "raw");
        chk("raw_rx_drop", 64'(n_drop - d0), 64'd1);
        chk("raw_len",     64'(tx_q.size() - b0), 64'd32);
        chk("raw_len2",    64'(tx2_q.size() - b2), 64'd32);
        bad = 0;
        for (int i = 0; i < 32; i++) begin
            t = DIG << (8 * i);
            if (b0 + i < tx_q.size() && tx_q[b0 + i] !== t[255:248]) bad++;
        end
        chk("raw_bytes_bad", 64'(bad), 64'd0);
        chk("raw_first_last", 64'({tx_q[b0], tx_q[b0+31]}), 64'hbaad);

        // Binary-safe payload: FF and 01 are plain data
        b0 = tx_q.size(); h0 = hv_q.size(); l0 = last_q.size();
        send_byte(8'h01); send_byte(8'h00); send_byte(8'h02);
        send_byte(8'hFF); send_byte(8'h01);
        wait_idle(2000, "bin");
        chk("bin_hv_count", 64'(hv_q.size() - h0), 64'd2);
        chk("bin_hv_bytes", 64'({hv_q[h0], hv_q[h0+1]}), 64'hFF01);
        chk("bin_last",     64'({last_q.size() - l0, 8'(last_q[l0])}), 64'h0000_0001_01);
        chk("bin_tx_len",   64'(tx_q.size() - b0), 64'd64);

        // Zero length, then an unknown command
        b0 = tx_q.size(); s0 = n_start; e0 = n_errcmd;
        send_byte(8'h01); send_byte(8'h00); send_byte(8'h00);
        wait_idle(200, "zero");
        chk("zero_tx_len",  64'(tx_q.size() - b0), 64'd1);
        chk("zero_tx_byte", 64'(tx_q[b0]), 64'h45);
        chk("zero_no_start", 64'(n_start - s0), 64'd0);
        send_byte(8'h7A);
        repeat (4) tick();
        chk("badcmd_err",   64'(n_errcmd - e0), 64'd1);
        chk("badcmd_no_tx", 64'(tx_q.size() - b0), 64'd1);
        chk("badcmd_busy",  64'(busy), 64'd0);

        // RX timeout inside the payload
        b0 = tx_q.size(); s0 = n_start; h0 = hv_q.size();
        send_byte(8'h01); send_byte(8'h00); send_byte(8'h05); send_byte(8'h61);
        n = 0;
        while (!tx_valid && n < 102) begin tick(); n++; end
        chk("tmo_within_102", 64'(tx_valid), 64'd1);
        chk("tmo_tx_data",    64'(tx_data), 64'h54);
        wait_idle(50, "tmo");
        chk("tmo_tx_len",  64'(tx_q.size() - b0), 64'd1);
        chk("tmo_started", 64'({n_start - s0, hv_q.size() - h0}), 64'h0000_0001_0000_0001);
        b0 = tx_q.size();
        send_abc(8'h01);
        wait_idle(2000, "after_tmo");
        chk_hex(b0, "after_tmo");

        // Random backpressure
        rdy_rand = 1;
        b0 = tx_q.size(); stab_err = stab_err;
        send_abc(8'h01);
        wait_idle(6000, "bp");
        chk_hex(b0, "bp");
        chk("bp_stable", 64'(stab_err), 64'd0);

        // Reset in the middle of a reply
        b0 = tx_q.size();
        send_abc(8'h01);
        n = 0;
        while (tx_q.size() - b0 < 10 && n < 4000) begin tick(); n++; end
        chk("rst_mid_reached", 64'(tx_q.size() - b0 >= 10), 64'd1);
        rst = 1'b1;
        tick();
        chk("rst_mid_valid", 64'({tx_valid, tx_valid2}), 64'd0);
        chk("rst_mid_busy",  64'({busy, busy2}), 64'd0);
        rst = 1'b0;
        b0 = tx_q.size();
        repeat (200) tick();
        chk("rst_mid_no_more", 64'(tx_q.size() - b0), 64'd0);
        chk("rst_mid_idle",    64'(busy), 64'd0);

        // Recovery after reset
        b0 = tx_q.size();
        send_abc(8'h01);
        wait_idle(6000, "recover");
        chk_hex(b0, "recover");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
